// File: rtl/game_pkg.sv
// Shared Space Invaders game types and screen/formation constants.
`default_nettype none
`timescale 1ns/1ps
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_INVADED = 2'd3
  } march_state_t;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int PLAYER_Y     = 450;
  localparam int ALIEN_COUNT  = 55;
  localparam int ALIEN_GRID_W = 200;
  localparam int FRAME_CNT_W  = 6;

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
// Frame counter that raises step_due once per period frames; period shrinks with alive_count.
`default_nettype none
`timescale 1ns/1ps
module step_timer
  import game_pkg::*;
#(
  parameter int PERIOD_MIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [5:0] alive_count,
  input  logic       clear,
  output logic       step_due
);

  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [FRAME_CNT_W:0]   cnt_inc;
  logic [FRAME_CNT_W:0]   period;

  assign period   = (FRAME_CNT_W+1)'(PERIOD_MIN) + {2'b00, alive_count[5:1]};
  assign cnt_inc  = {1'b0, frame_cnt} + 1'b1;
  assign step_due = frame_tick && !pause && !clear && (cnt_inc >= period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (clear) begin
      frame_cnt <= '0;
    end else if (frame_tick && !pause) begin
      frame_cnt <= step_due ? '0 : cnt_inc[FRAME_CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alien_march_ctrl.sv
// Alien formation sequencer: owns the origin, marches/descends on timer steps, flags clear/invasion.
`default_nettype none
`timescale 1ns/1ps
module alien_march_ctrl
  import game_pkg::*;
#(
  parameter int X_START    = 100,
  parameter int Y_START    = 50,
  parameter int GRID_W     = ALIEN_GRID_W,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = SCREEN_W,
  parameter int STEP_X     = 4,
  parameter int STEP_Y     = 10,
  parameter int INVADE_Y   = 440,
  parameter int PERIOD_MIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic [5:0] alive_count,
  output logic [9:0] alien_x,
  output logic [9:0] alien_y,
  output logic       dir_left,
  output logic       step,
  output logic       wave_clear,
  output logic       invaded
);

  march_state_t state, state_n;
  logic [9:0]   x_n, y_n;
  logic         dir_n, step_n, clear_n, inv_n;
  logic         step_due, timer_tick;
  logic [10:0]  right_edge, y_down;
  logic         at_right, at_left;

  // Timer only advances while the wave is live; start clears it.
  assign timer_tick = frame_tick && (state == ST_MARCH) && (alive_count != 6'd0);

  step_timer #(
    .PERIOD_MIN (PERIOD_MIN)
  ) u_step_timer (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (timer_tick),
    .pause       (pause),
    .alive_count (alive_count),
    .clear       (start),
    .step_due    (step_due)
  );

  assign right_edge = {1'b0, alien_x} + 11'(GRID_W + STEP_X);
  assign at_right   = right_edge > 11'(X_MAX);
  assign at_left    = {1'b0, alien_x} < 11'(X_MIN + STEP_X);
  assign y_down     = {1'b0, alien_y} + 11'(STEP_Y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      alien_x    <= 10'(X_START);
      alien_y    <= 10'(Y_START);
      dir_left   <= 1'b0;
      step       <= 1'b0;
      wave_clear <= 1'b0;
      invaded    <= 1'b0;
    end else begin
      state      <= state_n;
      alien_x    <= x_n;
      alien_y    <= y_n;
      dir_left   <= dir_n;
      step       <= step_n;
      wave_clear <= clear_n;
      invaded    <= inv_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = alien_x;
    y_n     = alien_y;
    dir_n   = dir_left;
    step_n  = 1'b0;
    clear_n = 1'b0;
    inv_n   = invaded;
    if (start) begin
      state_n = ST_MARCH;
      x_n     = 10'(X_START);
      y_n     = 10'(Y_START);
      dir_n   = 1'b0;
      inv_n   = 1'b0;
    end else begin
      case (state)
        ST_MARCH: begin
          // Wave clear wins over a step due in the same cycle.
          if (alive_count == 6'd0) begin
            state_n = ST_CLEAR;
            clear_n = 1'b1;
          end else if (step_due) begin
            step_n = 1'b1;
            if (dir_left ? at_left : at_right) begin
              y_n   = y_down[9:0];
              dir_n = ~dir_left;
              if (y_down >= 11'(INVADE_Y)) begin
                state_n = ST_INVADED;
                inv_n   = 1'b1;
              end
            end else if (dir_left) begin
              x_n = alien_x - 10'(STEP_X);
            end else begin
              x_n = alien_x + 10'(STEP_X);
            end
          end
        end
        ST_CLEAR: state_n = ST_IDLE;
        default:  state_n = state;
      endcase
    end
  end

endmodule
`default_nettype wire
